// File: rtl/keypad_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scan                                                              |
// | Scans a 4x4 active-low matrix keypad and debounces it over whole frames. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module keypad_scan #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);
    localparam int c_div_w = $clog2(SCAN_DIV);
    localparam int c_cnt_w = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_deb_max  = c_cnt_w'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_col_idx;
    logic [4:0]         r_acc_n;
    logic [3:0]         r_acc_code;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [3:0]         r_cand;
    logic [3:0]         w_cand_nxt;
    logic               w_accept;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_multi_key;
    logic               w_tc;
    logic               w_frame_end;
    logic [3:0]         w_hits;
    logic [2:0]         w_col_n;
    logic [1:0]         w_col_row;
    logic [4:0]         w_frame_n;
    logic [3:0]         w_frame_code;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_tc        = (r_div == c_div_last);
    assign w_frame_end = w_tc && (r_col_idx == 2'd3);
    assign col         = ~(4'b0001 << r_col_idx);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
        end else if (w_tc) begin
            r_div     <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_div     <= r_div + 1'b1;
        end
    end

    // Per-column contribution; the frame total folds in the column sampled now.
    assign w_hits  = ~r_row_sync;
    assign w_col_n = {2'b00, w_hits[0]} + {2'b00, w_hits[1]}
                   + {2'b00, w_hits[2]} + {2'b00, w_hits[3]};

    always_comb begin
        w_col_row = 2'd0;
        if (w_hits[0])      w_col_row = 2'd0;
        else if (w_hits[1]) w_col_row = 2'd1;
        else if (w_hits[2]) w_col_row = 2'd2;
        else if (w_hits[3]) w_col_row = 2'd3;
    end

    assign w_frame_n    = r_acc_n + {2'b00, w_col_n};
    assign w_frame_code = (w_col_n != 3'd0) ? {r_col_idx, w_col_row} : r_acc_code;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc_n    <= 5'd0;
            r_acc_code <= 4'd0;
        end else if (w_frame_end) begin
            r_acc_n    <= 5'd0;
            r_acc_code <= 4'd0;
        end else if (w_tc) begin
            r_acc_n    <= w_frame_n;
            r_acc_code <= w_frame_code;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                IDLE: begin
                    if (w_frame_n == 5'd1) begin
                        w_state_nxt = DEBOUNCE;
                        w_cand_nxt  = w_frame_code;
                        w_cnt_nxt   = c_cnt_w'(1);
                    end
                end
                DEBOUNCE: begin
                    if ((w_frame_n == 5'd1) && (w_frame_code == r_cand)) begin
                        if (w_cnt_inc == c_deb_max) begin
                            w_state_nxt = PRESSED;
                            w_cnt_nxt   = '0;
                            w_accept    = 1'b1;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                PRESSED: begin
                    if (w_frame_n == 5'd0) begin
                        w_state_nxt = RELEASE;
                        w_cnt_nxt   = c_cnt_w'(1);
                    end
                end
                RELEASE: begin
                    if (w_frame_n == 5'd0) begin
                        if (w_cnt_inc == c_deb_max) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_multi_key <= 1'b0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept)    r_key_code  <= r_cand;
            if (w_frame_end) r_multi_key <= (w_frame_n >= 5'd2);
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign multi_key = r_multi_key;
    assign key_held  = (r_state == PRESSED) || (r_state == RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for keypad_scan: directed frame table, bounce/reset sequences,
// and random frames against a frame-level reference model.
module tb_keypad_scan;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;
    logic [15:0] keys;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct packed {
        logic [15:0] k;
        logic        v;
        logic        h;
        logic        m;
        logic [3:0]  code;
    } vec_t;
    vec_t tbl [36];

    // frame-level reference model state
    int          m_run, m_quiet;
    logic        m_held, m_valid, m_multi;
    logic [3:0]  m_cand, m_code;
    logic [15:0] cur;
    logic [3:0]  one;
    int          early;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    always #5 CLK = ~CLK;

    // keypad matrix: key index = col*4 + row pulls its row low when its column strobes
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Apply a key pattern for one frame starting at a frame-end negedge.
    task automatic run_frame(input logic [15:0] k, input string tag);
        int stray;
        stray = 0;
        keys = k;
        for (int i = 0; i < FRAME - 1; i++) begin
            @(negedge CLK);
            if (key_valid) stray++;
        end
        @(negedge CLK);
        check({tag, "_midframe_valid"}, 8'(stray), 8'd0);
    endtask

    task automatic check_outs(input string tag, input logic v, input logic h,
                              input logic m, input logic [3:0] c);
        check({tag, "_valid"}, {7'd0, key_valid}, {7'd0, v});
        check({tag, "_held"},  {7'd0, key_held},  {7'd0, h});
        check({tag, "_multi"}, {7'd0, multi_key}, {7'd0, m});
        check({tag, "_code"},  {4'd0, key_code},  {4'd0, c});
    endtask

    function automatic void model_frame(input logic [15:0] k);
        int n;
        logic [3:0] code;
        n = $countones(k);
        code = 4'd0;
        for (int i = 15; i >= 0; i--) if (k[i]) code = 4'(i);
        m_valid = 1'b0;
        m_multi = (n >= 2);
        if (!m_held) begin
            if (m_run > 0 && n == 1 && code == m_cand) m_run++;
            else if (m_run > 0) m_run = 0;
            else if (n == 1) begin m_cand = code; m_run = 1; end
            if (m_run == DEB) begin
                m_valid = 1'b1; m_held = 1'b1; m_code = m_cand; m_run = 0; m_quiet = 0;
            end
        end else begin
            if (n == 0) m_quiet++; else m_quiet = 0;
            if (m_quiet == DEB) begin m_held = 1'b0; m_quiet = 0; end
        end
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        m_run = 0; m_quiet = 0; m_held = 1'b0; m_cand = 4'd0; m_code = 4'd0;
    endtask

    initial begin
        tbl[0]  = '{16'h0200, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{16'h0200, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{16'h0200, 1'b1, 1'b1, 1'b0, 4'h9};
        tbl[3]  = '{16'h0200, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[4]  = '{16'h0200, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[5]  = '{16'h0200, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[6]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[7]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[8]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'h9};
        tbl[9]  = '{16'h0200, 1'b0, 1'b0, 1'b0, 4'h9};
        tbl[10] = '{16'h0200, 1'b0, 1'b0, 1'b0, 4'h9};
        tbl[11] = '{16'h0200, 1'b1, 1'b1, 1'b0, 4'h9};
        tbl[12] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[13] = '{16'h0200, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[14] = '{16'h0200, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[15] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[16] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'h9};
        tbl[17] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'h9};
        tbl[18] = '{16'h8001, 1'b0, 1'b0, 1'b1, 4'h9};
        tbl[19] = '{16'h8001, 1'b0, 1'b0, 1'b1, 4'h9};
        tbl[20] = '{16'h8000, 1'b0, 1'b0, 1'b0, 4'h9};
        tbl[21] = '{16'h8000, 1'b0, 1'b0, 1'b0, 4'h9};
        tbl[22] = '{16'h8000, 1'b1, 1'b1, 1'b0, 4'hF};
        tbl[23] = '{16'h0008, 1'b0, 1'b1, 1'b0, 4'hF};
        tbl[24] = '{16'h0018, 1'b0, 1'b1, 1'b1, 4'hF};
        tbl[25] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'hF};
        tbl[26] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'hF};
        tbl[27] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'hF};
        tbl[28] = '{16'h0002, 1'b0, 1'b0, 1'b0, 4'hF};
        tbl[29] = '{16'h0004, 1'b0, 1'b0, 1'b0, 4'hF};
        tbl[30] = '{16'h0004, 1'b0, 1'b0, 1'b0, 4'hF};
        tbl[31] = '{16'h0004, 1'b0, 1'b0, 1'b0, 4'hF};
        tbl[32] = '{16'h0004, 1'b1, 1'b1, 1'b0, 4'h2};
        tbl[33] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'h2};
        tbl[34] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'h2};
        tbl[35] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'h2};

        keys = 16'h0000;
        RST  = 1'b1;
        one  = 4'b0001;
        repeat (3) @(negedge CLK);
        check("reset_col", {4'd0, col}, 8'h0E);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 4'h0);
        RST = 1'b0;

        // idle scan: column strobe walks every SCAN_DIV cycles, nothing reported
        early = 0;
        for (int e = 1; e <= FRAME; e++) begin
            @(negedge CLK);
            if (key_valid || key_held) early++;
            check($sformatf("idle_col_e%0d", e), {4'd0, col}, {4'd0, ~(one << ((e / SCAN_DIV) % 4))});
        end
        check("idle_activity", 8'(early), 8'd0);

        for (int i = 0; i < 36; i++) begin
            run_frame(tbl[i].k, $sformatf("tbl%0d", i));
            check_outs($sformatf("tbl%0d", i), tbl[i].v, tbl[i].h, tbl[i].m, tbl[i].code);
        end

        // bounce: key 9 toggles every 10 cycles, then stays pressed from t=82
        early = 0;
        for (int t = 0; t < 8 * FRAME; t++) begin
            if (t >= 82)     keys = 16'h0200;
            else if (t >= 2) keys = (((t - 2) / 10) % 2 == 0) ? 16'h0200 : 16'h0000;
            else             keys = 16'h0000;
            @(negedge CLK);
            if (t + 1 < 8 * FRAME && key_valid) early++;
        end
        check("bounce_early_valid", 8'(early), 8'd0);
        check_outs("bounce_accept", 1'b1, 1'b1, 1'b0, 4'h9);

        for (int i = 0; i < DEB; i++) run_frame(16'h0000, "bounce_rel");
        check_outs("bounce_released", 1'b0, 1'b0, 1'b0, 4'h9);

        // reset mid-debounce with the key still held
        run_frame(16'h0200, "rstdeb_f1");
        run_frame(16'h0200, "rstdeb_f2");
        check_outs("rstdeb_pre", 1'b0, 1'b0, 1'b0, 4'h9);
        repeat (6) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rstdeb_async_col", {4'd0, col}, 8'h0E);
        check_outs("rstdeb_async", 1'b0, 1'b0, 1'b0, 4'h0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        run_frame(16'h0200, "rstdeb_a1");
        check_outs("rstdeb_a1", 1'b0, 1'b0, 1'b0, 4'h0);
        run_frame(16'h0200, "rstdeb_a2");
        check_outs("rstdeb_a2", 1'b0, 1'b0, 1'b0, 4'h0);
        run_frame(16'h0200, "rstdeb_a3");
        check_outs("rstdeb_a3", 1'b1, 1'b1, 1'b0, 4'h9);

        // random frames against the reference model
        keys = 16'h0000;
        do_reset();
        cur = 16'h0000;
        for (int f = 0; f < 80; f++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 5) cur = cur;
            else if (sel < 7) cur = 16'h0000;
            else if (sel < 9) cur = 16'h0001 << $urandom_range(0, 15);
            else cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            model_frame(cur);
            run_frame(cur, $sformatf("rnd%0d", f));
            check_outs($sformatf("rnd%0d", f), m_valid, m_held, m_multi, m_code);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
